// File: rtl/fetch_unit.sv
`default_nettype none
// =============================================================================
// fetch_unit: instruction fetch over an SRAM-like req/resp bus, one request in
// flight, FIFO towards ID, squash on redirect. Option macro: FETCH_ADEF_EN.
// Revision: 1.0
// =============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h1c000000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        inst_req,
  output logic        inst_wr,
  output logic [1:0]  inst_size,
  output logic [31:0] inst_addr,
  output logic [31:0] inst_wdata,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        id_allow_in,
  output logic        if_to_id_valid,
  output logic [31:0] if_to_id_pc,
  output logic [31:0] if_to_id_inst,
  output logic        if_to_id_excp
);
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(BUF_DEPTH);
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(BUF_DEPTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
`ifdef FETCH_ADEF_EN
  localparam logic [1:0] S_HALT = 2'd3;
`endif

  logic [1:0]       state, next_state;
  logic [31:0]      fpc, req_addr;
  logic             discard;
  logic [31:0]      fifo_pc   [BUF_DEPTH];
  logic [31:0]      fifo_inst [BUF_DEPTH];
`ifdef FETCH_ADEF_EN
  logic             fifo_excp [BUF_DEPTH];
`endif
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count, count_after, eff_count;
  logic             pop, push, adef, data_push, launch;
  logic [31:0]      launch_pc;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    pop  = (count != '0) && id_allow_in;
    adef = 1'b0;
`ifdef FETCH_ADEF_EN
    adef = (state == S_REQ) && (req_addr[1:0] != 2'b00);
`endif
    data_push   = (state == S_WAIT) && inst_data_ok && !discard && !br_taken;
    push        = data_push || (adef && !br_taken);
    count_after = count + CNT_W'(push) - CNT_W'(pop);
    // a redirect flushes the FIFO, so occupancy seen by the launch check is zero
    eff_count   = br_taken ? '0 : count_after;
    launch_pc   = br_taken ? br_target : fpc;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (eff_count < DEPTH) next_state = S_REQ;
      S_REQ: begin
`ifdef FETCH_ADEF_EN
        if (adef) next_state = br_taken ? S_IDLE : S_HALT;
        else
`endif
        if (inst_addr_ok) next_state = S_WAIT;
      end
      S_WAIT: if (inst_data_ok) next_state = (eff_count < DEPTH) ? S_REQ : S_IDLE;
`ifdef FETCH_ADEF_EN
      S_HALT: if (br_taken) next_state = S_IDLE;
`endif
      default: next_state = S_IDLE;
    endcase
  end

  assign launch = ((state == S_IDLE) || (state == S_WAIT)) && (next_state == S_REQ);

  always_ff @(posedge clk) begin
    if (reset) begin
      fpc      <= RESET_PC;
      req_addr <= '0;
      discard  <= 1'b0;
    end else begin
      if (launch) begin
        req_addr <= launch_pc;
        fpc      <= launch_pc + 32'd4;
      end else if (br_taken) begin
        fpc <= br_target;
      end
      // a bus request already issued cannot be withdrawn, so its data is dropped later
      if ((state == S_WAIT) && inst_data_ok)
        discard <= 1'b0;
      else if (br_taken && (((state == S_REQ) && !adef) || (state == S_WAIT)))
        discard <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || br_taken) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        fifo_pc[wr_ptr]   <= req_addr;
        fifo_inst[wr_ptr] <= adef ? 32'h0 : inst_rdata;
`ifdef FETCH_ADEF_EN
        fifo_excp[wr_ptr] <= adef;
`endif
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count_after;
    end
  end

  always_comb begin
    inst_req       = (state == S_REQ) && !adef;
    inst_wr        = 1'b0;
    inst_size      = 2'b10;
    inst_addr      = {req_addr[31:2], 2'b00};
    inst_wdata     = '0;
    if_to_id_valid = (count != '0);
    if_to_id_pc    = '0;
    if_to_id_inst  = '0;
    if_to_id_excp  = 1'b0;
    if (if_to_id_valid) begin
      if_to_id_pc   = fifo_pc[rd_ptr];
      if_to_id_inst = fifo_inst[rd_ptr];
`ifdef FETCH_ADEF_EN
      if_to_id_excp = fifo_excp[rd_ptr];
`endif
    end
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch stage for the LoongArch pipeline, replacing the single-cycle BRAM fetch with a fetch over an SRAM-like request/response bus with variable memory latency. It keeps one request in flight, buffers returned instructions in a small FIFO so fetch continues while ID stalls, and squashes in-flight and buffered work on a branch redirect from ID. It sits between the instruction memory bus and the ID stage.

## Interface
- RESET_PC, 32'h1c000000, first fetch address after reset
- BUF_DEPTH, 2, instruction FIFO entries (power of 2, ≥1)

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- inst_req  out  1  bus request valid
- inst_wr  out  1  tied 0
- inst_size  out  2  tied 2'b10 (word)
- inst_addr  out  32  request address
- inst_wdata  out  32  tied 0
- inst_addr_ok  in  1  request accepted this cycle
- inst_data_ok  in  1  read data valid this cycle
- inst_rdata  in  32  read data
- br_taken  in  1  redirect pulse from ID, one cycle
- br_target  in  32  redirect address
- id_allow_in  in  1  ID accepts an instruction
- if_to_id_valid  out  1  FIFO head valid
- if_to_id_pc  out  32  head PC
- if_to_id_inst  out  32  head instruction
- if_to_id_excp  out  1  head carries fetch address error (ADEF)

## Operation
- Registers: fpc (next address to request), req_addr, state, discard flag, FIFO of {pc, inst, excp}, count.
- States: IDLE (no request), REQ (inst_req=1, inst_addr=req_addr), WAIT (accepted, awaiting data_ok).
- IDLE→REQ when count < BUF_DEPTH: req_addr<=fpc, fpc<=fpc+4.
- REQ: inst_addr and inst_req held stable until inst_addr_ok; never withdrawn. On addr_ok → WAIT.
- WAIT: on data_ok, push {req_addr, inst_rdata, 0} unless discard; clear discard; if count after push/pop < BUF_DEPTH → REQ directly (latching fpc as above), else IDLE.
- Pop when if_to_id_valid && id_allow_in. Push and pop in the same cycle leave count unchanged.
- br_taken: fpc<=br_target; FIFO flushed (count<=0, any same-cycle push/pop ignored). If state is REQ or WAIT (including addr_ok or data_ok in that cycle), that request's data is discarded: discard<=1, or the same-cycle data_ok is dropped. Repeated br_taken only reloads fpc. From IDLE, next request uses br_target.
- Outputs: if_to_id_valid = count != 0; pc/inst/excp are the FIFO head, 0 when empty.

## Timing
- Reset: inst_req=0, inst_addr=0, if_to_id_valid=0, head outputs 0, fpc=RESET_PC, state IDLE, discard 0.
- First cycle after reset: IDLE→REQ; inst_req=1 with addr RESET_PC in the second cycle after reset.
- Latency: if_to_id_valid rises the cycle after data_ok; no bypass.
- Zero-wait memory (addr_ok in REQ cycle, data_ok next cycle): one instruction per 2 cycles.
- Full FIFO: no new request is issued. The in-flight request always has a slot reserved, because a request issues only when count < BUF_DEPTH.
- Reset mid-transaction: all state cleared; a later data_ok in IDLE is ignored.

## Configuration
- FETCH_ADEF_EN defined: on entering REQ with fpc[1:0]≠0, no bus request is issued. Instead push {fpc, 32'h0, 1} and enter a HALT state that issues nothing until br_taken, then resume from br_target.
- Undefined: inst_addr = {req_addr[31:2],2'b00}, if_to_id_excp tied 0, no HALT state.

## Test plan
- Reset, zero-wait memory, id_allow_in=1 -> inst_addr 1c000000, 1c000004, 1c000008; valid with matching pc/inst every 2 cycles.
- addr_ok delayed 3 cycles, data_ok 2 cycles later -> inst_addr stable throughout; a single push with pc 1c000000.
- id_allow_in=0 for 10 cycles, BUF_DEPTH=2 -> exactly 2 entries buffered, inst_req low; release -> in-order drain, fetch resumes at 1c000008.
- br_taken (target 1c000100) while WAIT for 1c000004 -> its data_ok dropped, FIFO empty, next request 1c000100, first valid pc 1c000100.
- br_taken coincident with data_ok and pop -> nothing pushed, count 0, next request br_target.
- FETCH_ADEF_EN, br_target 1c000102 -> no inst_req, head pc 1c000102 excp=1; next br_taken 1c000200 resumes fetch.
